// File: rtl/div_seq_if.sv
// Request/response bundle between the ALU/HiLo datapath and the sequential divider.
// The datapath side drives operands and start; the divider side returns status and {HI, LO}.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     dataA;
    logic [WIDTH-1:0]     dataB;
    logic [5:0]           Signal;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [2*WIDTH-1:0]   dataOut;

    modport master (
        output start, dataA, dataB, Signal,
        input  busy, done, div_by_zero, dataOut
    );

    modport slave (
        input  start, dataA, dataB, Signal,
        output busy, done, div_by_zero, dataOut
    );
endinterface

// File: rtl/div_seq.sv
// Restoring shift-subtract divider, one quotient bit per clock, signed (DIV) or unsigned (DIVU).
// Produces {remainder, quotient} for the HI/LO pair; divide-by-zero short-circuits to a fixed result.
module div_seq #(
    parameter int         WIDTH     = 32,
    parameter logic [5:0] DIV_CODE  = 6'd26,
    parameter logic [5:0] DIVU_CODE = 6'd27
) (
    input  logic      clk,
    input  logic      firstart,
    div_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_reg,    state_next;
    logic [CNT_W-1:0]     count_reg,    count_next;
    logic [WIDTH-1:0]     dvd_reg,      dvd_next;
    logic [WIDTH-1:0]     dvs_reg,      dvs_next;
    logic [WIDTH:0]       rem_reg,      rem_next;
    logic                 sign_q_reg,   sign_q_next;
    logic                 sign_r_reg,   sign_r_next;
    logic                 zero_reg,     zero_next;
    logic                 done_reg,     done_next;
    logic                 dbz_reg,      dbz_next;
    logic [2*WIDTH-1:0]   data_out_reg, data_out_next;

    logic                 accept;
    logic                 is_div;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH:0]       shifted;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign is_div = (bus.Signal == DIV_CODE);
    assign accept = (state_reg == IDLE) && bus.start &&
                    ((bus.Signal == DIV_CODE) || (bus.Signal == DIVU_CODE));
    assign sign_a = is_div && bus.dataA[WIDTH-1];
    assign sign_b = is_div && bus.dataB[WIDTH-1];

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        dvd_next      = dvd_reg;
        dvs_next      = dvs_reg;
        rem_next      = rem_reg;
        sign_q_next   = sign_q_reg;
        sign_r_next   = sign_r_reg;
        zero_next     = zero_reg;
        done_next     = 1'b0;
        dbz_next      = dbz_reg;
        data_out_next = data_out_reg;
        shifted       = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
        quot_fix      = sign_q_reg ? -dvd_reg : dvd_reg;
        rem_fix       = sign_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    dbz_next   = 1'b0;
                    count_next = '0;
                    rem_next   = '0;
                    if (bus.dataB == '0) begin
                        // Raw dividend is kept so it can be returned as the remainder.
                        zero_next   = 1'b1;
                        dvd_next    = bus.dataA;
                        dvs_next    = '0;
                        sign_q_next = 1'b0;
                        sign_r_next = 1'b0;
                        state_next  = FIX;
                    end else begin
                        zero_next   = 1'b0;
                        dvd_next    = sign_a ? -bus.dataA : bus.dataA;
                        dvs_next    = sign_b ? -bus.dataB : bus.dataB;
                        sign_q_next = sign_a ^ sign_b;
                        sign_r_next = sign_a;
                        state_next  = CALC;
                    end
                end
            end
            CALC: begin
                // The dividend register doubles as the quotient: bits enter at the LSB as dividend bits leave the MSB.
                if (shifted >= {1'b0, dvs_reg}) begin
                    rem_next = shifted - {1'b0, dvs_reg};
                    dvd_next = {dvd_reg[WIDTH-2:0], 1'b1};
                end else begin
                    rem_next = shifted;
                    dvd_next = {dvd_reg[WIDTH-2:0], 1'b0};
                end
                count_next = count_reg + 1'b1;
                if (count_reg == CNT_W'(WIDTH - 1))
                    state_next = FIX;
            end
            FIX: begin
                if (zero_reg) begin
                    data_out_next = {dvd_reg, {WIDTH{1'b1}}};
                    dbz_next      = 1'b1;
                end else begin
                    data_out_next = {rem_fix, quot_fix};
                end
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge firstart) begin
        if (firstart) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            dvd_reg      <= '0;
            dvs_reg      <= '0;
            rem_reg      <= '0;
            sign_q_reg   <= 1'b0;
            sign_r_reg   <= 1'b0;
            zero_reg     <= 1'b0;
            done_reg     <= 1'b0;
            dbz_reg      <= 1'b0;
            data_out_reg <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            dvd_reg      <= dvd_next;
            dvs_reg      <= dvs_next;
            rem_reg      <= rem_next;
            sign_q_reg   <= sign_q_next;
            sign_r_reg   <= sign_r_next;
            zero_reg     <= zero_next;
            done_reg     <= done_next;
            dbz_reg      <= dbz_next;
            data_out_reg <= data_out_next;
        end
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = done_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.dataOut     = data_out_reg;
endmodule
